// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Holds the FSM state encoding, byte-enable/word-mask constants and the starvation counter helper.
package mem_port_arbiter_pkg;

    localparam int unsigned BE_W       = 4;
    localparam int unsigned STARVE_W   = 4;
    localparam int unsigned BYTE_OFF_W = 2;

    localparam logic [BE_W-1:0]       BE_ALL    = 4'b1111;
    localparam logic [BYTE_OFF_W-1:0] WORD_MASK = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    // Saturating increment of the consecutive-data-grant counter.
    function automatic logic [STARVE_W-1:0] starve_inc(
        input logic [STARVE_W-1:0] cnt,
        input logic [STARVE_W-1:0] lim
    );
        return (cnt >= lim) ? lim : cnt + STARVE_W'(1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between the IF and MEM stages.
// Data wins ties; a bounded count of data grants while a fetch waits forces the fetch through.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [BE_W-1:0]   d_be,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_stall,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_e          state_q,     state_d;
    logic [STARVE_W-1:0] starve_q,    starve_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q,    mem_be_d;

    logic starving_c;
    logic unused_addr_lsb;

    // Requesters own alignment; the byte offset never reaches the memory.
    assign unused_addr_lsb = ^{if_addr[BYTE_OFF_W-1:0], d_addr[BYTE_OFF_W-1:0]};

    assign starving_c = if_req && (starve_q == STARVE_LIM);

    // Grant decision, memory-side register loading and starvation accounting.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;

        case (state_q)
            IDLE: begin
                if (!if_req) begin
                    starve_d = '0;
                end
                if (d_req && !starving_c) begin
                    state_d     = GNT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = {d_addr[ADDR_W-1:BYTE_OFF_W], WORD_MASK};
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_we ? d_be : BE_ALL;
                    if (if_req) begin
                        starve_d = starve_inc(starve_q, STARVE_LIM);
                    end
                end else if (if_req) begin
                    state_d     = GNT_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {if_addr[ADDR_W-1:BYTE_OFF_W], WORD_MASK};
                    mem_wdata_d = '0;
                    mem_be_d    = BE_ALL;
                    starve_d    = '0;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    // Completion is the ack seen while granted; read data passes straight through.
    assign if_ready  = (state_q == GNT_I) && mem_ack;
    assign d_ready   = (state_q == GNT_D) && mem_ack;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign if_stall  = if_req && !if_ready;
    assign d_stall   = d_req && !d_ready;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a memory model with programmable latency,
// requester tasks, and a scoreboard of expected grants checked by a monitor.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready, if_stall;
    logic              d_req = 1'b0, d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [3:0]        d_be = '0;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready, d_stall;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata = '0;

    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } grant_t;

    grant_t exp_q[$];
    grant_t cur;
    bit     have_cur = 1'b0;
    int     n_checks = 0;
    int     n_errors = 0;

    int   mem_lat = 1;
    bit   mem_en = 1'b1;
    int   mem_cnt = 0;
    logic ack_model = 1'b0;
    logic stray_ack = 1'b0;
    bit   prev_req = 1'b0;
    bit   prev_rdy = 1'b0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_ack = ack_model | stray_ack;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h0050_0513;
        return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
    endfunction

    function automatic void push_f(input logic [31:0] a);
        grant_t g;
        g.is_d = 1'b0; g.we = 1'b0; g.addr = a & ~32'h3; g.wdata = '0; g.be = 4'hF;
        exp_q.push_back(g);
    endfunction

    function automatic void push_d(input logic we, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [3:0] be);
        grant_t g;
        g.is_d = 1'b1; g.we = we; g.addr = a & ~32'h3; g.wdata = wd;
        g.be = we ? be : 4'hF;
        exp_q.push_back(g);
    endfunction

    // Memory model: acks on the mem_lat-th cycle of a request.
    initial begin
        forever begin
            @(negedge clk);
            if (!mem_req || !mem_en) begin
                ack_model = 1'b0;
                mem_cnt   = 0;
            end else begin
                mem_cnt++;
                ack_model = (mem_cnt >= mem_lat);
            end
            mem_rdata = ack_model ? mem_word(mem_addr) : 32'hBAD0_BAD0;
        end
    end

    // Monitor: pops expected grants, checks held fields, ready pulses and stalls.
    initial begin
        forever begin
            @(negedge clk); #2;
            if (reset) begin
                have_cur = 1'b0;
            end else begin
                if (prev_rdy) begin
                    check("rdy_pulse", {62'd0, if_ready, d_ready}, 0);
                    check("req_drop", mem_req, 0);
                end
                if (mem_req && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        check("grant_unexp", 1, 0);
                        have_cur = 1'b0;
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1'b1;
                        if (!cur.is_d) check("starve_clr", dut.starve_q, 0);
                    end
                end
                if (mem_req && have_cur) begin
                    check("mem_we", mem_we, cur.we);
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_be", mem_be, cur.be);
                    if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
                end
                if (if_ready || d_ready) begin
                    if (!have_cur) begin
                        check("rdy_unexp", {62'd0, if_ready, d_ready}, 0);
                    end else begin
                        check("rdy_sel", {62'd0, if_ready, d_ready}, cur.is_d ? 2'b01 : 2'b10);
                        if (!cur.is_d) check("if_rdata", if_rdata, mem_word(cur.addr));
                        else if (!cur.we) check("d_rdata", d_rdata, mem_word(cur.addr));
                        have_cur = 1'b0;
                    end
                end
                check("if_stall", if_stall, if_req & ~if_ready);
                check("d_stall", d_stall, d_req & ~d_ready);
            end
            prev_req = mem_req;
            prev_rdy = if_ready | d_ready;
        end
    end

    task automatic do_fetch(input logic [31:0] a, input int budget, output int waited);
        if_req = 1'b1; if_addr = a; waited = 0;
        do begin
            @(negedge clk); #1;
            waited++;
        end while (!if_ready && waited < budget);
        if (!if_ready) check("if_timeout", 0, 1);
        if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input int budget, output int waited);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be; waited = 0;
        do begin
            @(negedge clk); #1;
            waited++;
        end while (!d_ready && waited < budget);
        if (!d_ready) check("d_timeout", 0, 1);
        d_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wi, wd, k;
        idle(3);
        reset = 1'b0;
        idle(1);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_ready", {62'd0, if_ready, d_ready}, 0);
        check("rst_stall", {62'd0, if_stall, d_stall}, 0);
        check("rst_state", dut.state_q, IDLE);
        check("rst_starve", dut.starve_q, 0);

        // Fetch-only, zero-wait memory, misaligned address.
        mem_lat = 1;
        push_f(32'h0000_0004);
        do_fetch(32'h0000_0006, 20, wi);
        check("fetch_lat", wi, 1);
        idle(2);

        // Store with three cycles of memory latency.
        mem_lat = 3;
        push_d(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
        do_data(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 20, wd);
        check("store_lat", wd, 3);
        idle(2);

        // Load: byte enables forced to all ones.
        mem_lat = 2;
        push_d(1'b0, 32'h10A, 32'h0, 4'b0101);
        do_data(1'b0, 32'h10A, 32'h0, 4'b0101, 20, wd);
        check("load_lat", wd, 2);
        idle(2);

        // Simultaneous requests: data first, fetch after one idle bubble.
        mem_lat = 1;
        push_d(1'b0, 32'h40, 32'h0, 4'hF);
        push_f(32'h80);
        fork
            do_data(1'b0, 32'h40, 32'h0, 4'hF, 20, wd);
            do_fetch(32'h80, 20, wi);
        join
        check("sim_d_lat", wd, 1);
        check("sim_i_lat", wi, 3);
        idle(2);

        // Starvation: four data grants, then the fetch, then remaining data.
        for (int j = 0; j < 4; j++) push_d(1'b0, 32'(32'h500 + 4 * j), 32'h0, 4'hF);
        push_f(32'h200);
        for (int j = 4; j < 6; j++) push_d(1'b0, 32'(32'h500 + 4 * j), 32'h0, 4'hF);
        fork
            do_fetch(32'h200, 60, wi);
            begin
                for (k = 0; k < 6; k++) do_data(1'b0, 32'(32'h500 + 4 * k), 32'h0, 4'hF, 20, wd);
            end
        join
        check("starve_wait", wi, 9);
        idle(2);

        // Requester drops its request while granted; ready still pulses.
        mem_lat = 3;
        push_d(1'b0, 32'h600, 32'h0, 4'hF);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; d_be = 4'hF;
        idle(1);
        d_req = 1'b0;
        wd = 0;
        while (!d_ready && wd < 10) begin idle(1); wd++; end
        check("drop_ready", d_ready, 1);
        idle(2);

        // Ack in IDLE is ignored.
        stray_ack = 1'b1;
        idle(1);
        check("idle_ack_rdy", {62'd0, if_ready, d_ready}, 0);
        stray_ack = 1'b0;
        idle(1);
        check("idle_ack_req", mem_req, 0);
        check("idle_ack_state", dut.state_q, IDLE);

        // Reset while a read is outstanding, then a late ack.
        mem_en = 1'b0;
        push_d(1'b0, 32'h300, 32'h0, 4'hF);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        idle(2);
        check("rst_pre_req", mem_req, 1);
        reset = 1'b1; d_req = 1'b0;
        idle(1);
        check("rst_mid_req", mem_req, 0);
        check("rst_mid_state", dut.state_q, IDLE);
        check("rst_mid_rdy", d_ready, 0);
        reset = 1'b0;
        idle(1);
        stray_ack = 1'b1;
        #1;
        check("late_ack_rdy", {62'd0, if_ready, d_ready}, 0);
        idle(1);
        stray_ack = 1'b0;
        check("late_ack_req", mem_req, 0);
        check("late_ack_state", dut.state_q, IDLE);
        mem_en = 1'b1;
        idle(2);

        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
